ioctl_mem_arbiter: RTL and testbench

- Sits between the ARM download front-end's ioctl_* word stream and a single-port external memory controller (SDRAM/SRAM) interface.
- Converts the ioctl_wr toggle protocol into buffered 16-bit write transactions. Shares the memory port between download traffic and one core requester using round-robin arbitration.
- Reports loaded image size, completion, and overflow so the core can release reset after the image is in memory.

---
 rtl/ioctl_mem_pkg.sv | 17 +
 rtl/ioctl_word_fifo.sv | 49 ++++
 rtl/ioctl_mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_ioctl_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ioctl_mem_pkg.sv
// Shared types and widths for the ioctl download / core memory arbiter.
package ioctl_mem_pkg;
  localparam int ADDR_W  = 25;
  localparam int DATA_W  = 16;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DL_WR    = 2'd1,
    ST_CORE_ACC = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_DL   = 1'b0,
    GNT_CORE = 1'b1
  } grant_t;
endpackage

// File: rtl/ioctl_word_fifo.sv
// Synchronous FIFO with full/empty flags; a push is accepted while full when a pop happens the same cycle.
module ioctl_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
               (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    dout     = mem_q[rd_ptr_q[PTR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= din;
  end
endmodule

// File: rtl/ioctl_mem_arbiter.sv
// Buffers ioctl download words and shares one memory port with a core requester (round-robin).
// Optional macro LOAD_CHECKSUM_EN enables the additive load_sum checksum.
module ioctl_mem_arbiter
  import ioctl_mem_pkg::*;
#(
  parameter int                FIFO_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 25'h0,
  parameter logic [7:0]        INDEX_MATCH = 8'hFF
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [DATA_W-1:0] ioctl_dout,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_din,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_dout,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [ADDR_W-1:0] load_size,
  output logic              load_done,
  output logic              overflow,
  output logic [DATA_W-1:0] load_sum
);
  localparam logic [ADDR_W-1:0] WORD_BYTES = 25'd2;

  logic               wr_prev_q, dl_prev_q;
  logic               index_ok, capture, dl_rise, dl_fall, push_ok;
  logic               core_req_eff;
  logic               fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_din, fifo_dout;
  logic [ADDR_W-1:0]  addr_end, size_base;

  arb_state_e         state_q, state_d;
  grant_t             last_grant_q, last_grant_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_din_q, mem_din_d;
  logic               core_ack_q, core_ack_d;
  logic [DATA_W-1:0]  core_dout_q, core_dout_d;
  logic [ADDR_W-1:0]  load_size_q, load_size_d;
  logic               load_done_q, load_done_d;
  logic               done_armed_q, done_armed_d;
  logic               overflow_q, overflow_d;

  always_comb begin
    index_ok  = (INDEX_MATCH == 8'hFF) || (ioctl_index == INDEX_MATCH);
    capture   = (ioctl_wr != wr_prev_q) && ioctl_download && index_ok;
    dl_rise   = ioctl_download && !dl_prev_q;
    dl_fall   = !ioctl_download && dl_prev_q;
    fifo_din  = {ioctl_addr + BASE_ADDR, ioctl_dout};
    push_ok   = capture && (!fifo_full || fifo_pop);
    addr_end  = ioctl_addr + WORD_BYTES;
    // The cycle in which core_ack is high still sees the finished request's core_req.
    core_req_eff = core_req && !core_ack_q;
  end

  ioctl_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk_sys),
    .reset (reset),
    .push  (capture),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    core_ack_d   = 1'b0;
    core_dout_d  = core_dout_q;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && (!core_req_eff || last_grant_q == GNT_CORE)) begin
          state_d    = ST_DL_WR;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = fifo_dout[ENTRY_W-1:DATA_W];
          mem_din_d  = fifo_dout[DATA_W-1:0];
        end else if (core_req_eff) begin
          state_d    = ST_CORE_ACC;
          mem_req_d  = 1'b1;
          mem_we_d   = core_we;
          mem_addr_d = core_addr;
          mem_din_d  = core_din;
        end
      end
      ST_DL_WR: begin
        if (mem_ack) begin
          fifo_pop     = 1'b1;
          mem_req_d    = 1'b0;
          last_grant_d = GNT_DL;
          state_d      = ST_IDLE;
        end
      end
      ST_CORE_ACC: begin
        if (mem_ack) begin
          core_ack_d = 1'b1;
          if (!mem_we_q) core_dout_d = mem_dout;
          mem_req_d    = 1'b0;
          last_grant_d = GNT_CORE;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    size_base   = dl_rise ? '0 : load_size_q;
    load_size_d = size_base;
    if (push_ok && (addr_end > size_base)) load_size_d = addr_end;

    overflow_d = dl_rise ? 1'b0 : overflow_q;
    if (capture && !push_ok) overflow_d = 1'b1;

    // load_done waits until the last buffered word has been acknowledged.
    done_armed_d = done_armed_q;
    load_done_d  = 1'b0;
    if (dl_fall) begin
      done_armed_d = 1'b1;
    end else if (dl_rise) begin
      done_armed_d = 1'b0;
    end else if (done_armed_q && fifo_empty && state_q != ST_DL_WR) begin
      load_done_d  = 1'b1;
      done_armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_prev_q    <= ioctl_wr;
      dl_prev_q    <= ioctl_download;
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_CORE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      core_ack_q   <= 1'b0;
      core_dout_q  <= '0;
      load_size_q  <= '0;
      load_done_q  <= 1'b0;
      done_armed_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_prev_q    <= ioctl_wr;
      dl_prev_q    <= ioctl_download;
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      core_ack_q   <= core_ack_d;
      core_dout_q  <= core_dout_d;
      load_size_q  <= load_size_d;
      load_done_q  <= load_done_d;
      done_armed_q <= done_armed_d;
      overflow_q   <= overflow_d;
    end
  end

`ifdef LOAD_CHECKSUM_EN
  logic [DATA_W-1:0] load_sum_q, load_sum_d;

  always_comb begin
    load_sum_d = dl_rise ? '0 : load_sum_q;
    if (state_q == ST_DL_WR && mem_ack) load_sum_d = load_sum_d + mem_din_q;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) load_sum_q <= '0;
    else       load_sum_q <= load_sum_d;
  end

  assign load_sum = load_sum_q;
`else
  assign load_sum = '0;
`endif

  assign core_ack  = core_ack_q;
  assign core_dout = core_dout_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign load_size = load_size_q;
  assign load_done = load_done_q;
  assign overflow  = overflow_q;
endmodule

// File: tb/tb_ioctl_mem_arbiter.sv
// Directed bench for ioctl_mem_arbiter: memory responder with scoreboard, core requester, download sequences.
module tb_ioctl_mem_arbiter;
  localparam logic [24:0] TB_BASE = 25'h1000;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic        core_req;
  logic        core_we;
  logic [24:0] core_addr;
  logic [15:0] core_din;
  logic        core_ack;
  logic [15:0] core_dout;
  logic        mem_req;
  logic        mem_we;
  logic [24:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_ack;
  logic [15:0] mem_dout;
  logic [24:0] load_size;
  logic        load_done;
  logic        overflow;
  logic [15:0] load_sum;

  ioctl_mem_arbiter #(
    .FIFO_DEPTH  (4),
    .BASE_ADDR   (TB_BASE),
    .INDEX_MATCH (8'h01)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .core_req       (core_req),
    .core_we        (core_we),
    .core_addr      (core_addr),
    .core_din       (core_din),
    .core_ack       (core_ack),
    .core_dout      (core_dout),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_ack        (mem_ack),
    .mem_dout       (mem_dout),
    .load_size      (load_size),
    .load_done      (load_done),
    .overflow       (overflow),
    .load_sum       (load_sum)
  );

  // Clock and watchdog
  always #5 clk_sys = ~clk_sys;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state: expected memory transactions {we, addr, din}
  logic [41:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  int          ack_delay   = 2;
  bit          allow_extra = 1'b0;
  logic [15:0] rd_data     = 16'h0000;
  int          core_go_cnt = 0;

  int          txn_cnt  = 0;
  logic [7:0]  kind_log = '0;
  int          ack_cnt  = 0;
  int          ack_wide = 0;
  logic        ack_prev = 1'b0;
  logic [15:0] ack_dout = '0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory controller model: checks each new request, acks after ack_delay cycles.
  initial begin
    logic [41:0] e;
    mem_ack  = 1'b0;
    mem_dout = '0;
    forever begin
      @(posedge clk_sys); #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        txn_cnt++;
        kind_log = {kind_log[6:0], mem_we};
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("mem_txn", {22'd0, mem_we, mem_addr, mem_din}, {22'd0, e});
        end else if (!allow_extra) begin
          check("mem_txn_unexpected", {22'd0, mem_we, mem_addr, mem_din}, 64'd0);
        end
        repeat (ack_delay) @(posedge clk_sys);
        #1;
        mem_ack  = 1'b1;
        mem_dout = rd_data;
      end
    end
  end

  // Core requester: one read of 25'h100 per core_go_cnt step, held through the core_ack cycle.
  initial begin
    int  served = 0;
    bit  drop_next = 1'b0;
    core_req  = 1'b0;
    core_we   = 1'b0;
    core_addr = '0;
    core_din  = '0;
    forever begin
      @(posedge clk_sys); #1;
      if (drop_next) begin
        core_req  = 1'b0;
        drop_next = 1'b0;
      end else if (core_req && core_ack) begin
        drop_next = 1'b1;
      end else if (!core_req && core_go_cnt != served) begin
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 25'h100;
        served++;
      end
    end
  end

  // Output monitor on the falling edge
  always @(negedge clk_sys) begin
    if (core_ack) begin
      ack_cnt++;
      if (ack_prev) ack_wide++;
      ack_dout = core_dout;
    end
    ack_prev = core_ack;
    if (load_done) done_cnt++;
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  task automatic send_word(input logic [24:0] a, input logic [15:0] d, input int gap, input bit expect_wr);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = ~ioctl_wr;
    if (expect_wr) exp_q.push_back({1'b1, a + TB_BASE, d});
    repeat (gap) @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_done(input string tag, input int bound);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < bound) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check(tag, 64'(done_cnt != base), 64'd1);
  endtask

  initial begin
    int done_base, txn_base, ack_base, wide_base, n;
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h01;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    do_reset();

    // Reset values
    check("rst_mem_req",   64'(mem_req),   64'd0);
    check("rst_mem_we",    64'(mem_we),    64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_din",   64'(mem_din),   64'd0);
    check("rst_core_ack",  64'(core_ack),  64'd0);
    check("rst_core_dout", 64'(core_dout), 64'd0);
    check("rst_load_size", 64'(load_size), 64'd0);
    check("rst_load_done", 64'(load_done), 64'd0);
    check("rst_overflow",  64'(overflow),  64'd0);
    check("rst_load_sum",  64'(load_sum),  64'd0);

    // Eight words, ack after 2 cycles
    ack_delay = 2;
    done_base = done_cnt;
    ioctl_download = 1'b1;
    for (int i = 0; i < 8; i++) send_word(25'(2 * i), 16'h1000 + 16'(i), 8, 1'b1);
    ioctl_download = 1'b0;
    wait_done("t1_load_done", 200);
    repeat (5) @(posedge clk_sys);
    #1;
    check("t1_done_pulses", 64'(done_cnt - done_base), 64'd1);
    check("t1_load_size",   64'(load_size), 64'd16);
    check("t1_overflow",    64'(overflow),  64'd0);
    check("t1_all_written", 64'(exp_q.size()), 64'd0);

    // Toggles ignored: download low, then wrong index
    txn_base = txn_cnt;
    for (int i = 0; i < 3; i++) send_word(25'h40 + 25'(2 * i), 16'hDEAD, 3, 1'b0);
    repeat (10) @(posedge clk_sys);
    #1;
    check("t4_no_req_dl0",    64'(txn_cnt - txn_base), 64'd0);
    check("t4_size_kept_dl0", 64'(load_size), 64'd16);
    ioctl_index    = 8'h03;
    ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) send_word(25'h80 + 25'(2 * i), 16'hBAD0, 3, 1'b0);
    repeat (10) @(posedge clk_sys);
    #1;
    check("t4_no_req_idx",    64'(txn_cnt - txn_base), 64'd0);
    check("t4_size_idx",      64'(load_size), 64'd0);
    check("t4_mem_req_low",   64'(mem_req),   64'd0);
    ioctl_index    = 8'h01;
    ioctl_download = 1'b0;

    // Overflow: slow memory, toggles every 4 cycles
    do_reset();
    ack_delay   = 20;
    allow_extra = 1'b1;
    ioctl_download = 1'b1;
    for (int i = 0; i < 8; i++) send_word(25'(2 * i), 16'h1000 + 16'(i), 4, i < 4);
    ioctl_download = 1'b0;
    wait_done("t2_load_done", 800);
    check("t2_overflow",     64'(overflow), 64'd1);
    check("t2_first_intact", 64'(exp_q.size()), 64'd0);
    allow_extra = 1'b0;
    ioctl_download = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    check("t2_overflow_clr", 64'(overflow),  64'd0);
    check("t2_size_clr",     64'(load_size), 64'd0);

    // Round-robin between download and a core read
    do_reset();
    ack_delay = 3;
    rd_data   = 16'h5A3C;
    ack_base  = ack_cnt;
    wide_base = ack_wide;
    send_word(25'h0, 16'h2000, 2, 1'b1);
    exp_q.push_back({1'b0, 25'h100, 16'h0000});
    core_go_cnt++;
    send_word(25'h2, 16'h2001, 2, 1'b1);
    send_word(25'h4, 16'h2002, 2, 1'b1);
    ioctl_download = 1'b0;
    wait_done("t3_load_done", 300);
    repeat (5) @(posedge clk_sys);
    #1;
    check("t3_grant_order", 64'(kind_log[3:0]), 64'b1011);
    check("t3_ack_count",   64'(ack_cnt - ack_base), 64'd1);
    check("t3_ack_width",   64'(ack_wide - wide_base), 64'd0);
    check("t3_dout_at_ack", 64'(ack_dout),  64'h5A3C);
    check("t3_dout_held",   64'(core_dout), 64'h5A3C);
    check("t3_all_served",  64'(exp_q.size()), 64'd0);
    check("t3_load_size",   64'(load_size), 64'd6);

    // Reset during a download write; stale ack arrives afterwards
    ioctl_download = 1'b1;
    do_reset();
    ack_delay = 8;
    ack_base  = ack_cnt;
    send_word(25'h20, 16'hBEEF, 1, 1'b1);
    n = 0;
    while (!mem_req && n < 10) begin
      @(posedge clk_sys); #1;
      n++;
    end
    check("t5_req_seen", 64'(mem_req), 64'd1);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    check("t5_req_dropped", 64'(mem_req), 64'd0);
    txn_base = txn_cnt;
    ioctl_addr = 25'h30;
    ioctl_wr   = ~ioctl_wr;
    @(posedge clk_sys); #1;
    ioctl_wr   = ~ioctl_wr;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    repeat (25) @(posedge clk_sys);
    #1;
    check("t5_no_new_txn",  64'(txn_cnt - txn_base), 64'd0);
    check("t5_mem_req_low", 64'(mem_req), 64'd0);
    check("t5_no_core_ack", 64'(ack_cnt - ack_base), 64'd0);
    check("t5_size_zero",   64'(load_size), 64'd0);
    check("t5_exp_empty",   64'(exp_q.size()), 64'd0);

    // Checksum of 16'hFFFF + 16'h0002
    ioctl_download = 1'b0;
    do_reset();
    ack_delay = 2;
    ioctl_download = 1'b1;
    send_word(25'h0, 16'hFFFF, 8, 1'b1);
    send_word(25'h2, 16'h0002, 8, 1'b1);
    ioctl_download = 1'b0;
    wait_done("t6_load_done", 200);
`ifdef LOAD_CHECKSUM_EN
    check("t6_load_sum", 64'(load_sum), 64'h0001);
`else
    check("t6_load_sum", 64'(load_sum), 64'h0000);
`endif
    check("t6_load_size", 64'(load_size), 64'd4);
    check("t6_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
